fp_div_iter: RTL and testbench



---
 rtl/fp_div_iter_if.sv | 28 ++
 rtl/fp_div_iter.sv | 196 +++++++++++++++++++
 tb/tb_fp_div_iter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fp_div_iter_if.sv
// Start/done handshake bundle for the iterative FP divider: operands in, quotient and flags out.
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         div_by_zero;
  logic         invalid;

  modport master (
    output start, a, b,
    input  busy, done, result, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754-style divider: restoring division, one quotient bit per cycle,
// DAZ inputs, FTZ outputs, round-to-nearest-even.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_iter_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int Q  = MAN_W + 3;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(Q);

  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] XONE    = XW'(1);
  localparam logic signed [XW-1:0] XZERO   = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_NAN} cls_t;

  function automatic cls_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = x[W-2:MAN_W];
    m = x[MAN_W-1:0];
    if (e == '0)       return (m == '0) ? C_ZERO : C_SUB;
    else if (e == '1)  return (m == '0) ? C_INF : C_NAN;
    else               return C_NORM;
  endfunction

  state_t                 state;
  logic                   sign;
  logic [MAN_W+1:0]       rem;
  logic [MAN_W:0]         dvs;
  logic [Q-1:0]           q;
  logic signed [XW-1:0]   exp;
  logic [CW-1:0]          cnt;
  logic                   busy_r, done_r, ovf_r, unf_r, dbz_r, inv_r;
  logic [W-1:0]           result_r;

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.overflow    = ovf_r;
  assign bus.underflow   = unf_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.invalid     = inv_r;

  // Operand classification and fixed results for the special cases.
  cls_t         ca, cb;
  logic         za, zb, sgn_in, special, sp_inv, sp_dbz;
  logic [W-1:0] sp_res;

  always_comb begin
    ca      = classify(bus.a);
    cb      = classify(bus.b);
    za      = (ca == C_ZERO) || (ca == C_SUB);
    zb      = (cb == C_ZERO) || (cb == C_SUB);
    sgn_in  = bus.a[W-1] ^ bus.b[W-1];
    special = 1'b1;
    sp_res  = '0;
    sp_inv  = 1'b0;
    sp_dbz  = 1'b0;
    if (ca == C_NAN || cb == C_NAN) begin
      sp_res = QNAN;
    end else if ((za && zb) || (ca == C_INF && cb == C_INF)) begin
      sp_res = QNAN;
      sp_inv = 1'b1;
    end else if (ca == C_INF) begin
      sp_res = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zb) begin
      sp_res = {sgn_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_dbz = 1'b1;
    end else if (cb == C_INF || za) begin
      sp_res = {sgn_in, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step.
  logic             ge;
  logic [MAN_W+1:0] rem_sub;

  always_comb begin
    ge      = (rem >= {1'b0, dvs});
    rem_sub = ge ? (rem - {1'b0, dvs}) : rem;
  end

  // Normalise, round to nearest even, then range-check.
  logic [Q-1:0]         qn;
  logic signed [XW-1:0] en, er;
  logic [MAN_W:0]       mant;
  logic                 guard, sticky, inc;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         nr_res;
  logic                 nr_ovf, nr_unf;

  always_comb begin
    qn     = q[Q-1] ? q : {q[Q-2:0], 1'b0};
    en     = q[Q-1] ? exp : exp - XONE;
    mant   = qn[Q-1:2];
    guard  = qn[1];
    sticky = qn[0] | (|rem);
    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    if (mant_r[MAN_W+1]) begin
      frac = mant_r[MAN_W:1];
      er   = en + XONE;
    end else begin
      frac = mant_r[MAN_W-1:0];
      er   = en;
    end
    nr_ovf = 1'b0;
    nr_unf = 1'b0;
    if (er >= EXP_MAX) begin
      nr_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      nr_ovf = 1'b1;
    end else if (er <= XZERO) begin
      nr_res = {sign, {(W-1){1'b0}}};
      nr_unf = 1'b1;
    end else begin
      nr_res = {sign, er[EXP_W-1:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      rem      <= '0;
      dvs      <= '0;
      q        <= '0;
      exp      <= '0;
      cnt      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dbz_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign <= sgn_in;
            if (special) begin
              result_r <= sp_res;
              ovf_r    <= 1'b0;
              unf_r    <= 1'b0;
              dbz_r    <= sp_dbz;
              inv_r    <= sp_inv;
              done_r   <= 1'b1;
              state    <= DONE;
            end else begin
              rem    <= {1'b0, 1'b1, bus.a[MAN_W-1:0]};
              dvs    <= {1'b1, bus.b[MAN_W-1:0]};
              exp    <= $signed({2'b00, bus.a[W-2:MAN_W]}) - $signed({2'b00, bus.b[W-2:MAN_W]}) + BIAS;
              q      <= '0;
              cnt    <= CW'(Q - 1);
              busy_r <= 1'b1;
              state  <= DIV;
            end
          end
        end
        DIV: begin
          rem <= {rem_sub[MAN_W:0], 1'b0};
          q   <= {q[Q-2:0], ge};
          if (cnt == '0) state <= NORM;
          else           cnt   <= cnt - CW'(1);
        end
        NORM: begin
          result_r <= nr_res;
          ovf_r    <= nr_ovf;
          unf_r    <= nr_unf;
          dbz_r    <= 1'b0;
          inv_r    <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter (binary32): directed cases plus random operands
// checked against a real-arithmetic reference model.
module tb_fp_div_iter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  fp_div_iter_if #(.EXP_W(8), .MAN_W(23)) bus ();
  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [31:0] r, ra, rb, er, prev;
  logic [3:0]  f, ef;
  logic        b1, bd, sp, seen_done;
  int          lat, n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.overflow, bus.underflow, bus.div_by_zero, bus.invalid};
  endfunction

  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    while (!bus.done && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Drive one operation; report result, flags, latency and busy at T+1 / at done.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    bus.a = xa; bus.b = xb; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    b1 = bus.busy;
    wait_done(40, n);
    lat = 1 + n;
    r   = bus.result;
    f   = flags();
    bd  = bus.busy;
  endtask

  task automatic run_chk(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] xr, input logic [3:0] xf, input int xlat);
    do_op(xa, xb);
    chk({tag, "_res"}, 64'(r), 64'(xr));
    chk({tag, "_flg"}, 64'(f), 64'(xf));
    chk({tag, "_lat"}, 64'(lat), 64'(xlat));
    chk({tag, "_busy1"}, 64'(b1), (xlat == 1) ? 64'd0 : 64'd1);
    chk({tag, "_busyd"}, 64'(bd), 64'd0);
  endtask

  // Reference: IEEE classification rules, then real-valued quotient rounded to nearest even.
  // Flags packed as {overflow, underflow, div_by_zero, invalid}.
  function automatic void model(input logic [31:0] xa, input logic [31:0] xb,
                                output logic [31:0] res, output logic [3:0] fl4, output bit spc);
    int  ea, eb, e, fl, be;
    bit  na, nb, ia, ib, za, zb, s;
    real m, sc, fr;
    ea = int'(xa[30:23]); eb = int'(xb[30:23]);
    na = (ea == 255) && (xa[22:0] != 0); nb = (eb == 255) && (xb[22:0] != 0);
    ia = (ea == 255) && (xa[22:0] == 0); ib = (eb == 255) && (xb[22:0] == 0);
    za = (ea == 0); zb = (eb == 0);
    s  = xa[31] ^ xb[31];
    fl4 = 4'b0000; spc = 1'b1;
    if (na || nb)                         res = 32'h7FC00000;
    else if ((za && zb) || (ia && ib)) begin res = 32'h7FC00000; fl4 = 4'b0001; end
    else if (ia)                          res = {s, 8'hFF, 23'h0};
    else if (zb) begin                    res = {s, 8'hFF, 23'h0}; fl4 = 4'b0010; end
    else if (ib || za)                    res = {s, 31'h0};
    else begin
      spc = 1'b0;
      m = real'(int'({1'b1, xa[22:0]})) / real'(int'({1'b1, xb[22:0]}));
      e = ea - eb;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      sc = m * 8388608.0;
      fl = $rtoi(sc);
      fr = sc - real'(fl);
      if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
      if (fl == 16777216) begin fl = 8388608; e++; end
      be = e + 127;
      if (be >= 255)     begin res = {s, 8'hFF, 23'h0}; fl4 = 4'b1000; end
      else if (be <= 0)  begin res = {s, 31'h0};        fl4 = 4'b0100; end
      else                     res = {s, 8'(be), 23'(fl)};
    end
  endfunction

  function automatic logic [31:0] gen();
    int k;
    logic [31:0] x;
    k = $urandom_range(0, 11);
    x = $urandom;
    case (k)
      0:       x[30:23] = 8'h00;
      1:       begin x[30:23] = 8'hFF; x[22:0] = '0; end
      2:       begin x[30:23] = 8'hFF; x[22] = 1'b1; end
      3, 4:    x[30:23] = 8'($urandom_range(1, 254));
      default: x[30:23] = 8'($urandom_range(100, 154));
    endcase
    return x;
  endfunction

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_res",  64'(bus.result), 64'd0);
    chk("rst_flg",  64'(flags()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_chk("basic",   32'h3FC00000, 32'h40300000, 32'h3F0BA2E9, 4'b0000, 28);
    run_chk("neg",     32'hC0600000, 32'hBFA00000, 32'h40333333, 4'b0000, 28);
    run_chk("divzero", 32'hC4FC74CD, 32'h00000000, 32'hFF800000, 4'b0010, 1);
    run_chk("zz",      32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
    run_chk("fin_inf", 32'h4128A3D7, 32'h7F800000, 32'h00000000, 4'b0000, 1);
    run_chk("nan_b",   32'h3F800000, 32'hFF800001, 32'h7FC00000, 4'b0000, 1);
    run_chk("inf_z",   32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000, 1);
    run_chk("ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 28);
    run_chk("unf",     32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 28);
    run_chk("daz",     32'h00400000, 32'h00400000, 32'h7FC00000, 4'b0001, 1);
    prev = r;

    // Re-pulse start at T+5: must be ignored; result holds until the new done.
    @(negedge clk);
    bus.a = 32'h3FC00000; bus.b = 32'h40300000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'h40000000; bus.b = 32'h3F800000;
    chk("hold_res", 64'(bus.result), 64'(prev));
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40, n);
    chk("restart_lat", 64'(6 + n), 64'd28);
    chk("restart_res", 64'(bus.result), 64'h3F0BA2E9);

    // Reset mid-operation at T+10.
    @(negedge clk);
    bus.a = 32'hC0600000; bus.b = 32'hBFA00000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_res",  64'(bus.result), 64'd0);
    chk("abort_flg",  64'(flags()), 64'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | bus.done;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen_done = seen_done | bus.done;
    end
    chk("abort_nodone", 64'(seen_done), 64'd0);
    run_chk("post_rst", 32'hC0600000, 32'hBFA00000, 32'h40333333, 4'b0000, 28);

    for (int i = 0; i < 60; i++) begin
      ra = gen();
      rb = gen();
      model(ra, rb, er, ef, sp);
      run_chk($sformatf("rnd%0d_%08h_%08h", i, ra, rb), ra, rb, er, ef, sp ? 1 : 28);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
